// File: rtl/shifter_pkg.sv
// Shared shifter definitions: FSM state encoding, default datapath width and
// the shift-amount width helper used by both shift directions.
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sl_state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Shift-amount field width; never narrower than one bit.
    function automatic int sl_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_left_seq_if.sv
// Request/result bundle for the sequential left shifter. The rot signal
// exists only when SHIFT_LEFT_ROTATE_EN is defined.
interface shift_left_seq_if import shifter_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    localparam int SLW = sl_width(WIDTH);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [SLW-1:0]   SL;
`ifdef SHIFT_LEFT_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] A_SL;
    logic             C;
    logic             busy;
    logic             done;

`ifdef SHIFT_LEFT_ROTATE_EN
    modport master (output start, A, SL, rot, input A_SL, C, busy, done);
    modport slave  (input start, A, SL, rot, output A_SL, C, busy, done);
`else
    modport master (output start, A, SL, input A_SL, C, busy, done);
    modport slave  (input start, A, SL, output A_SL, C, busy, done);
`endif

endinterface

// File: rtl/shift_left_seq_sl_step.sv
// Single-position left shift or rotate of a WIDTH-bit vector; reports the bit
// leaving the MSB.
module sl_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    input  logic             rot,
    output logic [WIDTH-1:0] dout,
    output logic             out_bit
);

    assign dout[0] = rot & din[WIDTH-1];

    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bit
        assign dout[gi] = din[gi-1];
    end

    assign out_bit = din[WIDTH-1];

endmodule

// File: rtl/shift_left_seq.sv
// Sequential left shifter: one bit position per clock, registered result,
// carry and done pulse. Define SHIFT_LEFT_ROTATE_EN to add the rot option.
module shift_left_seq import shifter_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    shift_left_seq_if.slave bus
);

    localparam int SLW = sl_width(WIDTH);

    sl_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SLW-1:0]   count_q, count_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_vec;
    logic             step_bit;

`ifdef SHIFT_LEFT_ROTATE_EN
    logic rot_q, rot_d;
`else
    logic rot_q;
    assign rot_q = 1'b0;
`endif

    sl_step #(.WIDTH(WIDTH)) u_step (
        .din     (shreg_q),
        .rot     (rot_q),
        .dout    (step_vec),
        .out_bit (step_bit)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        c_d     = c_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SHIFT_LEFT_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            SHIFT: begin
                shreg_d = step_vec;
                c_d     = step_bit;
                count_d = count_q - SLW'(1);
                if (count_q == SLW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request, enabling back-to-back ops.
                if (bus.start) begin
                    shreg_d = bus.A;
                    count_d = bus.SL;
                    c_d     = 1'b0;
`ifdef SHIFT_LEFT_ROTATE_EN
                    rot_d   = bus.rot;
`endif
                    if (bus.SL != '0) begin
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_LEFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_LEFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign bus.A_SL = shreg_q;
    assign bus.C    = c_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: vector table plus hand-written
// reset, busy-drop and back-to-back sequences, scored through a queue.
module tb_shift_left_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_left_seq_if #(.WIDTH(4)) bus ();

    shift_left_seq #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] a;
        logic [1:0] sl;
        logic [3:0] exp_r;
        logic       exp_c;
    } vec_t;

    typedef struct {
        logic [3:0] r;
        logic       c;
        int         lat;
        int         busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int actual, input int required);
        n_cmp++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    function automatic void model(input logic [3:0] a, input logic [1:0] sl, input logic rot,
                                  output logic [3:0] r, output logic c);
        logic [7:0] tmp;
        tmp = {4'b0000, a} << sl;
        r   = tmp[3:0] | (rot ? tmp[7:4] : 4'b0000);
        c   = tmp[4];
    endfunction

    // Drives a request for the next edge and records what should come back.
    task automatic drive_start(input logic [3:0] a, input logic [1:0] sl, input logic rot,
                               input logic [3:0] exp_r, input logic exp_c);
        exp_t e;
        bus.start = 1'b1;
        bus.A     = a;
        bus.SL    = sl;
`ifdef SHIFT_LEFT_ROTATE_EN
        bus.rot   = rot;
`endif
        e.r           = exp_r;
        e.c           = exp_c;
        e.lat         = int'(sl) + 1;
        e.busy_cycles = int'(sl);
        exp_q.push_back(e);
    endtask

    // Waits through the accepting edge for done, then scores against the queue head.
    task automatic wait_done(input string name);
        exp_t e;
        int   lat;
        int   busy_cnt;
        bit   timed_out;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        timed_out = 1'b0;
        while (bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (lat >= 10) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        if (timed_out) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got no done within %0d cycles, required done at %0d", name, lat, e.lat);
            return;
        end
        check({name, " latency"}, lat, e.lat);
        check({name, " busy_cycles"}, busy_cnt, e.busy_cycles);
        check({name, " A_SL"}, int'(bus.A_SL), int'(e.r));
        check({name, " C"}, int'(bus.C), int'(e.c));
        check({name, " busy_at_done"}, int'(bus.busy), 0);
        $display("txn %s: A_SL=%b C=%0d latency=%0d busy_cycles=%0d", name, bus.A_SL, bus.C, lat, busy_cnt);
    endtask

    vec_t vecs[6];

    initial begin
        logic [3:0] r;
        logic       c;
        logic [3:0] ra;
        logic [1:0] rs;
        int         seen;

        bus.start = 1'b0;
        bus.A     = '0;
        bus.SL    = '0;
`ifdef SHIFT_LEFT_ROTATE_EN
        bus.rot   = 1'b0;
`endif

        vecs[0] = '{a: 4'b1011, sl: 2'd2, exp_r: 4'b1100, exp_c: 1'b0};
        vecs[1] = '{a: 4'b0111, sl: 2'd3, exp_r: 4'b1000, exp_c: 1'b1};
        vecs[2] = '{a: 4'b1010, sl: 2'd0, exp_r: 4'b1010, exp_c: 1'b0};
        vecs[3] = '{a: 4'b1111, sl: 2'd1, exp_r: 4'b1110, exp_c: 1'b1};
        vecs[4] = '{a: 4'b0001, sl: 2'd3, exp_r: 4'b1000, exp_c: 1'b0};
        vecs[5] = '{a: 4'b1001, sl: 2'd1, exp_r: 4'b0010, exp_c: 1'b1};

        repeat (2) @(negedge clk);
        check("reset A_SL", int'(bus.A_SL), 0);
        check("reset C", int'(bus.C), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive_start(vecs[i].a, vecs[i].sl, 1'b0, vecs[i].exp_r, vecs[i].exp_c);
            wait_done($sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d done_one_cycle", i), int'(bus.done), 0);
            check($sformatf("vec%0d A_SL_hold", i), int'(bus.A_SL), int'(vecs[i].exp_r));
        end

        for (int i = 0; i < 6; i++) begin
            ra = 4'($urandom_range(0, 15));
            rs = 2'($urandom_range(0, 3));
            model(ra, rs, 1'b0, r, c);
            @(negedge clk);
            drive_start(ra, rs, 1'b0, r, c);
            wait_done($sformatf("rand%0d", i));
        end

        // Request during SHIFT must be dropped, not queued.
        @(negedge clk);
        drive_start(4'b1011, 2'd3, 1'b0, 4'b1000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 4'b0001;
        bus.SL    = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.done === 1'b1) begin
                seen++;
                check("busy_drop A_SL", int'(bus.A_SL), 4'b1000);
                check("busy_drop C", int'(bus.C), 1);
            end
            @(negedge clk);
        end
        void'(exp_q.pop_front());
        check("busy_drop done_count", seen, 1);
        $display("txn busy_drop: done pulses=%0d A_SL=%b", seen, bus.A_SL);

        // Back-to-back: second request issued in the DONE cycle.
        @(negedge clk);
        drive_start(4'b0111, 2'd3, 1'b0, 4'b1000, 1'b1);
        wait_done("b2b_first");
        drive_start(4'b0001, 2'd1, 1'b0, 4'b0010, 1'b0);
        wait_done("b2b_second");

`ifdef SHIFT_LEFT_ROTATE_EN
        @(negedge clk);
        drive_start(4'b1011, 2'd1, 1'b1, 4'b0111, 1'b1);
        wait_done("rot_1011");
        for (int i = 0; i < 4; i++) begin
            ra = 4'($urandom_range(0, 15));
            rs = 2'($urandom_range(0, 3));
            model(ra, rs, 1'b1, r, c);
            @(negedge clk);
            drive_start(ra, rs, 1'b1, r, c);
            wait_done($sformatf("rot_rand%0d", i));
        end
`endif

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        drive_start(4'b1111, 2'd3, 1'b0, 4'b1000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst A_SL", int'(bus.A_SL), 0);
        check("midrst C", int'(bus.C), 0);
        check("midrst busy", int'(bus.busy), 0);
        check("midrst done", int'(bus.done), 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("midrst no_activity_after", seen, 0);
        check("midrst A_SL_after", int'(bus.A_SL), 0);
        $display("txn midrst: A_SL=%b C=%0d busy=%0d done=%0d", bus.A_SL, bus.C, bus.busy, bus.done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
